// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives instruction memory, presents {pc, instr} to decode with a one-entry skid buffer.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] imem_address,
    output logic [31:0] imem_read_write,
    output logic [31:0] imem_data_in,
    input  logic [31:0] imem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_fault
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic [XLEN-1:0] buf_pc;
    logic [XLEN-1:0] buf_instr;
    logic            inflight;
    logic            buf_valid;
    logic            fault;

    logic [XLEN-1:0] target;
    logic            misalign;
    logic            present;
    logic            issue;
    logic            stall_capture;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target   = redirect_pc;
    assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    // Low address bits are dropped so a bad target still fetches a word boundary.
    assign target   = redirect_pc & ~XLEN'(3);
    assign misalign = 1'b0;
`endif

    assign imem_read_write = '0;
    assign imem_data_in    = '0;
    assign fetch_fault     = fault;

    // A redirect kills whatever is presented this cycle; a fault blocks delivery until an aligned redirect.
    assign present  = reset_n && (buf_valid || inflight) && !redirect_valid && !fault;
    assign if_valid = present;

    assign issue = !misalign && (redirect_valid || (!fault && (!present || if_ready)));

    assign stall_capture = inflight && !buf_valid && !if_ready && !redirect_valid;

    always_comb begin
        if (!reset_n) begin
            imem_address = RESET_PC;
        end else if (redirect_valid) begin
            imem_address = target;
        end else begin
            imem_address = pc;
        end
    end

    // Outputs are forced to zero during reset so stale state never leaks to decode.
    always_comb begin
        if_pc    = '0;
        if_instr = '0;
        if (reset_n) begin
            if (buf_valid) begin
                if_pc    = buf_pc;
                if_instr = buf_instr;
            end else if (inflight) begin
                if_pc    = inflight_pc;
                if_instr = imem_data_out;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            buf_valid   <= 1'b0;
            buf_pc      <= '0;
            buf_instr   <= '0;
            fault       <= 1'b0;
        end else if (misalign) begin
            pc        <= target;
            inflight  <= 1'b0;
            buf_valid <= 1'b0;
            fault     <= 1'b1;
        end else begin
            if (redirect_valid) begin
                fault <= 1'b0;
            end

            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= imem_address;
                pc          <= imem_address + XLEN'(PC_STEP);
            end else begin
                inflight <= 1'b0;
            end

            // Skid buffer: park the returning word while decode stalls, drop it on redirect.
            if (redirect_valid) begin
                buf_valid <= 1'b0;
            end else if (stall_capture) begin
                buf_valid <= 1'b1;
                buf_pc    <= inflight_pc;
                buf_instr <= imem_data_out;
            end else if (buf_valid && if_ready) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized stream checked against an in-order PC model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    logic        clock;
    logic        reset_n;
    logic [31:0] imem_address;
    logic [31:0] imem_read_write;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_address   (imem_address),
        .imem_read_write(imem_read_write),
        .imem_data_in   (imem_data_in),
        .imem_data_out  (imem_data_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_fault    (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents are a fixed function of the address; read data arrives one cycle later.
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    always @(posedge clock) imem_data_out <= word(imem_address);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Applies one reset cycle and leaves the bench in the first cycle after reset_n rises.
    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0200_0000;
        tick();
        tick();
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b pc=%h instr=%h, expected 0/0/0", if_valid, if_pc, if_instr);
        end
        checks++;
        if (imem_address !== RESET_PC) begin
            errors++;
            $display("FAIL reset_address: got %h expected %h", imem_address, RESET_PC);
        end
        checks++;
        if (fetch_fault !== 1'b0 || imem_read_write !== 32'h0 || imem_data_in !== 32'h0) begin
            errors++;
            $display("FAIL reset_consts: fault=%b rw=%h din=%h expected zeros", fetch_fault, imem_read_write, imem_data_in);
        end
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_startup();
        do_reset();
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b0 || imem_address !== RESET_PC) begin
            errors++;
            $display("FAIL startup_first: valid=%b addr=%h expected 0/%h", if_valid, imem_address, RESET_PC);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== RESET_PC + 32'(4 * i) || if_instr !== word(RESET_PC + 32'(4 * i))) begin
                errors++;
                $display("FAIL startup_stream%0d: valid=%b pc=%h instr=%h expected pc %h", i, if_valid, if_pc,
                         if_instr, RESET_PC + 32'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_stall_and_redirect();
        do_reset();
        tick();
        tick();
        // Presenting 0x01000004: stall three cycles.
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h0100_0004 || if_instr !== word(32'h0100_0004) ||
                imem_address !== 32'h0100_0008) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b pc=%h instr=%h addr=%h expected pc 01000004 addr 01000008",
                         i, if_valid, if_pc, if_instr, imem_address);
            end
            tick();
        end
        if_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0100_0004) begin
            errors++;
            $display("FAIL stall_release: valid=%b pc=%h expected 01000004", if_valid, if_pc);
        end
        tick();
        if_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0100_0008 || if_instr !== word(32'h0100_0008)) begin
            errors++;
            $display("FAIL stall_next: valid=%b pc=%h instr=%h expected 01000008", if_valid, if_pc, if_instr);
        end
        tick();
        tick();
        // 0x01000008 now sits in the buffer; redirect with if_ready high must drop it.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0100;
        if_ready       = 1'b1;
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b0 || imem_address !== 32'h0100_0100) begin
            errors++;
            $display("FAIL redirect_cycle: valid=%b addr=%h expected 0/01000100", if_valid, imem_address);
        end
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h0100_0100 + 32'(4 * i) ||
                if_instr !== word(32'h0100_0100 + 32'(4 * i))) begin
                errors++;
                $display("FAIL redirect_target%0d: valid=%b pc=%h instr=%h expected pc %h", i, if_valid, if_pc,
                         if_instr, 32'h0100_0100 + 32'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid: got %b expected 0", if_valid);
        end
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b0 || imem_address !== RESET_PC) begin
            errors++;
            $display("FAIL midreset_after: valid=%b addr=%h expected 0/%h", if_valid, imem_address, RESET_PC);
        end
        tick();
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin
            errors++;
            $display("FAIL midreset_restart: valid=%b pc=%h expected %h", if_valid, if_pc, RESET_PC);
        end
        tick();
    endtask

    task automatic test_misalign();
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0102;
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_cycle: valid=%b expected 0", if_valid);
        end
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (fetch_fault !== 1'b1 || if_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_fault%0d: fault=%b valid=%b expected 1/0", i, fetch_fault, if_valid);
            end
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0200;
        tick();
        redirect_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (fetch_fault !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0100_0200) begin
            errors++;
            $display("FAIL misalign_clear: fault=%b valid=%b pc=%h expected 0/1/01000200", fetch_fault, if_valid, if_pc);
        end
        tick();
`else
        @(negedge clock);
        checks++;
        if (fetch_fault !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0100_0100 || if_instr !== word(32'h0100_0100)) begin
            errors++;
            $display("FAIL misalign_masked: fault=%b valid=%b pc=%h instr=%h expected 0/1/01000100", fetch_fault,
                     if_valid, if_pc, if_instr);
        end
        tick();
`endif
    endtask

    // The presented word is always the head of the program-order stream; after start-up
    // decode sees something every cycle except a redirect cycle.
    task automatic test_random(input int n);
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        do_reset();
        tick();
        exp_pc = RESET_PC;
        for (int c = 0; c < n; c++) begin
            redirect_valid = ($urandom_range(0, 9) == 0);
            tgt            = RESET_PC | (32'($urandom_range(0, 1023)) << 2);
            redirect_pc    = tgt;
            if_ready       = ($urandom_range(0, 9) < 7);
            @(negedge clock);
            checks++;
            if (if_valid !== !redirect_valid) begin
                errors++;
                $display("FAIL rand_valid c%0d: got %b expected %b", c, if_valid, !redirect_valid);
            end
            if (redirect_valid) begin
                checks++;
                if (imem_address !== tgt) begin
                    errors++;
                    $display("FAIL rand_redirect_addr c%0d: got %h expected %h", c, imem_address, tgt);
                end
                exp_pc = tgt;
            end else if (if_valid) begin
                checks++;
                if (if_pc !== exp_pc || if_instr !== word(exp_pc)) begin
                    errors++;
                    $display("FAIL rand_order c%0d: pc=%h instr=%h expected pc %h instr %h", c, if_pc, if_instr,
                             exp_pc, word(exp_pc));
                end
                if (if_ready) exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        #1;
        test_reset();
        test_startup();
        test_stall_and_redirect();
        test_reset_mid();
        test_misalign();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the five-stage core; sits directly upstream of the instruction memory.
- Owns the PC and drives the memory address each cycle.
- Captures the memory read data, which is registered with 1-cycle latency, and presents {pc, instr} to decode over a valid/ready handshake.
- Holds a one-entry skid buffer for decode stalls and accepts redirects from execute.

Parameters:
- RESET_PC, 32'h01000000, PC loaded on reset; first fetch address.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  synchronous active-low reset.
- imem_address  output  32  byte address to instruction memory.
- imem_read_write  output  32  constant 0 (read only).
- imem_data_in  output  32  constant 0.
- imem_data_out  input  32  instruction word, valid the cycle after its address is driven.
- redirect_valid  input  1  execute requests PC change (taken branch/jump).
- redirect_pc  input  32  target PC.
- if_valid  output  1  {if_pc, if_instr} valid to decode.
- if_ready  input  1  decode accepts this cycle.
- if_pc  output  32  PC of presented instruction.
- if_instr  output  32  presented instruction word.
- fetch_fault  output  1  misaligned-target flag; tied 0 unless the macro is defined.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- State: pc, inflight, inflight_pc, buf_valid, buf_pc, buf_instr.
- Reset (reset_n=0 at posedge):
  - pc=RESET_PC; inflight=0; buf_valid=0; fault=0.
  - During reset cycles: if_valid=0, if_pc=0, if_instr=0, imem_address=RESET_PC.
  - Reset mid-operation discards any in-flight or buffered word.
- Output mux (combinational):
  - If buf_valid: present buf_pc/buf_instr.
  - Else if inflight: present inflight_pc/imem_data_out.
  - if_valid = (buf_valid | inflight) & ~redirect_valid.
- Issue rule: issue = redirect_valid | ~if_valid | if_ready.
  - On issue: inflight<=1, inflight_pc<=imem_address, pc<=imem_address+PC_STEP (32-bit wrap, no overflow flag).
  - No issue: inflight<=0 and pc held.
- Address mux: imem_address = redirect_valid ? redirect_pc : pc.
  - The redirect target is fetched in the redirect cycle itself.
- Decode stall (inflight & ~buf_valid & ~if_ready & ~redirect_valid): imem_data_out is captured into the buffer, buf_valid<=1.
- Buffer drain: buf_valid & if_ready -> buf_valid<=0. A new issue may occur in the same cycle.
- Invariant: buf_valid and inflight are never both 1.
- Latency:
  - Address to if_valid: 1 cycle.
  - First if_valid: 2nd cycle after reset_n rises.
  - Redirect to target if_valid: 1 cycle. Words in flight or buffered at redirect are dropped (buf_valid<=0).
- Throughput: 1 instruction/cycle with if_ready held high.
- Simultaneous redirect and if_ready: redirect wins; nothing is accepted that cycle.
- Redirect during reset: ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined, and redirect_pc[1:0]!=0 with redirect_valid=1:
  - No issue; inflight<=0; buf_valid<=0; pc<=redirect_pc.
  - fetch_fault<=1, sticky; if_valid held 0.
  - The condition clears on reset or on the next aligned redirect (fault<=0, normal issue).
- Not defined:
  - fetch_fault=0 always.
  - Redirect target low 2 bits forced to 0 before use.

Test Plan:
- Reset release, if_ready=1, memory holding 0x00000013 at 0x01000000/04/08 -> if_valid from 2nd cycle; if_pc 0x01000000, 0x01000004, 0x01000008 on consecutive cycles.
- Decode stall: if_ready=0 for 3 cycles while pc 0x01000004 is presented -> if_pc/if_instr stable, imem_address holds 0x01000008; release -> 0x01000004 then 0x01000008, no loss or duplicate.
- Redirect redirect_pc=0x01000100 while 0x01000008 is valid and stalled -> same-cycle if_valid=0, imem_address=0x01000100; next cycle if_pc=0x01000100.
- Redirect coincident with buf_valid=1 and if_ready=1 -> buffered word dropped; next if_pc equals the redirect target.
- reset_n low for 1 cycle mid-stream -> if_valid=0 next cycle; fetch restarts at 0x01000000.
- With FETCH_MISALIGN_CHECK_EN, redirect_pc=0x01000102 -> fetch_fault=1, if_valid=0 until redirect_pc=0x01000200, then fault=0 and if_pc=0x01000200. Without the macro, the same stimulus gives if_pc=0x01000100.
